// File: rtl/rgb_pkg.sv
// rgb_pkg: shared types and constants for the RGB PWM LED driver.
//   rgb_state_e : request/hold FSM states
//   rgb_t       : 3-bit color {red, green, blue}
//   *_IDX       : bit positions of each channel inside rgb_t
//   C_*         : common color constants
package rgb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    HOLD
  } rgb_state_e;

  typedef logic [2:0] rgb_t;

  localparam int unsigned R_IDX = 2;
  localparam int unsigned G_IDX = 1;
  localparam int unsigned B_IDX = 0;

  localparam rgb_t C_OFF   = 3'b000;
  localparam rgb_t C_RED   = 3'b100;
  localparam rgb_t C_GREEN = 3'b010;
  localparam rgb_t C_BLUE  = 3'b001;
  localparam rgb_t C_WHITE = 3'b111;

endpackage

// File: rtl/rgb_pwm_counter.sv
// rgb_pwm_counter: free-running PWM period counter.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset (cnt -> 0)
//   cnt  : counter value, 0 .. 2^CNT_W-1, wraps to 0
//   wrap : high in the cycle where cnt is at its maximum
module rgb_pwm_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt  = r_cnt;
  assign wrap = (r_cnt == '1);

endmodule

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: drives an RGB LED from 3-bit on/off color requests.
// Requests are accepted over valid/ready, applied only at PWM period
// boundaries, and then held for MIN_PERIODS full periods before the next
// request is accepted. One brightness duty is shared by all channels.
//   clk, rst                     : clock / asynchronous active-high reset
//   req_valid, req_ready         : request handshake
//   req_red/green/blue           : requested channel enables
//   brightness                   : duty, captured at each period start
//   led_r/g/b                    : registered PWM outputs
//   frame_tick                   : registered pulse in the first cycle of a period
module rgb_pwm_driver
  import rgb_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned MIN_PERIODS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_red,
  input  logic             req_green,
  input  logic             req_blue,
  input  logic [CNT_W-1:0] brightness,
  output logic             led_r,
  output logic             led_g,
  output logic             led_b,
  output logic             frame_tick
);

  localparam int unsigned HOLD_W = (MIN_PERIODS > 1) ? $clog2(MIN_PERIODS) : 1;

  logic [CNT_W-1:0] w_cnt;
  logic             w_wrap;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_duty_nxt;
  rgb_t             w_col_nxt;
  logic             w_on;

  rgb_state_e       r_state;
  rgb_t             r_pend;
  rgb_t             r_col;
  logic [HOLD_W-1:0] r_hold;
  logic [CNT_W-1:0] r_duty;
  rgb_t             r_led;
  logic             r_tick;

  rgb_pwm_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .cnt (w_cnt),
    .wrap(w_wrap)
  );

  // The LED register is loaded from the values that cnt/duty/col take on at
  // the same edge, so a new period's first LED state coincides with
  // frame_tick instead of trailing it by one clock.
  always_comb begin
    w_cnt_nxt  = w_cnt + CNT_W'(1);
    w_duty_nxt = r_duty;
    w_col_nxt  = r_col;
    if (w_wrap) begin
      w_duty_nxt = brightness;
      if (r_state == PEND) begin
        w_col_nxt = r_pend;
      end
    end
    w_on = (w_cnt_nxt < w_duty_nxt);
  end

  // Request / hold FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pend  <= C_OFF;
      r_col   <= C_OFF;
      r_hold  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_pend  <= {req_red, req_green, req_blue};
            r_state <= PEND;
          end
        end
        PEND: begin
          if (w_wrap) begin
            r_col   <= r_pend;
            r_hold  <= '0;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (w_wrap) begin
            if (r_hold == HOLD_W'(MIN_PERIODS - 1)) begin
              r_state <= IDLE;
            end else begin
              r_hold <= r_hold + HOLD_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Duty capture and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_duty <= '0;
      r_led  <= C_OFF;
      r_tick <= 1'b0;
    end else begin
      r_duty <= w_duty_nxt;
      r_led  <= w_col_nxt & {3{w_on}};
      r_tick <= w_wrap;
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign led_r      = r_led[R_IDX];
  assign led_g      = r_led[G_IDX];
  assign led_b      = r_led[B_IDX];
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb_rgb_pwm_driver: directed self-checking bench for rgb_pwm_driver with
// CNT_W=4, MIN_PERIODS=2. Expected LED values are queued per period when a
// request is driven and popped each cycle as the DUT produces output.
module tb_rgb_pwm_driver;
  import rgb_pkg::*;

  localparam int unsigned CW  = 4;
  localparam int unsigned MP  = 2;
  localparam int unsigned PER = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_red = 1'b0;
  logic          req_green = 1'b0;
  logic          req_blue = 1'b0;
  logic [CW-1:0] brightness = '0;
  logic          req_ready;
  logic          led_r;
  logic          led_g;
  logic          led_b;
  logic          frame_tick;

  int          errors = 0;
  int          checks = 0;
  int unsigned tb_cnt = 0;
  bit          wrapped = 1'b0;
  rgb_t        exp_q[$];
  rgb_t        seq[3];

  rgb_pwm_driver #(
    .CNT_W(CW),
    .MIN_PERIODS(MP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_red   (req_red),
    .req_green (req_green),
    .req_blue  (req_blue),
    .brightness(brightness),
    .led_r     (led_r),
    .led_g     (led_g),
    .led_b     (led_b),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (bench cnt=%0d)", tag, obs, exp, tb_cnt);
    end
  endtask

  task automatic chk_ready(input string tag, input logic e);
    chk(tag, {7'b0, req_ready}, {7'b0, e});
  endtask

  task automatic chk_all_off(input string tag);
    chk(tag, {4'b0, led_r, led_g, led_b, frame_tick}, 8'h00);
  endtask

  task automatic drive_req(input rgb_t c);
    req_valid = 1'b1;
    req_red   = c[R_IDX];
    req_green = c[G_IDX];
    req_blue  = c[B_IDX];
  endtask

  task automatic push_period(input rgb_t c, input int unsigned duty);
    for (int unsigned k = 0; k < PER; k++) begin
      exp_q.push_back((k < duty) ? c : C_OFF);
    end
  endtask

  // Advance to the next sample point (falling edge) and check outputs.
  task automatic tick();
    rgb_t e;
    logic ft;
    @(negedge clk);
    tb_cnt = (tb_cnt + 1) % PER;
    if (tb_cnt == 0) wrapped = 1'b1;
    ft = (tb_cnt == 0) && wrapped;
    chk("frame_tick", {7'b0, frame_tick}, {7'b0, ft});
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("leds", {5'b0, led_r, led_g, led_b}, {5'b0, e});
    end
  endtask

  task automatic wait_to(input int unsigned c);
    tick();
    while (tb_cnt != c) tick();
  endtask

  // Called at the sample point of the wrap cycle in which a pending color
  // is applied; checks two held periods and the return of req_ready.
  task automatic hold_check(input rgb_t c, input int unsigned duty);
    push_period(c, duty);
    push_period(c, duty);
    repeat (PER) tick();
    chk_ready("hold_busy1", 1'b0);
    repeat (PER) tick();
    chk_ready("hold_busy2", 1'b0);
    tick();
    chk_ready("hold_release", 1'b1);
  endtask

  initial begin
    seq[0] = C_RED;
    seq[1] = C_BLUE;
    seq[2] = C_RED;

    // Reset state
    @(negedge clk);
    chk_all_off("reset_outputs");
    chk_ready("reset_ready", 1'b1);
    rst = 1'b0;
    tb_cnt = 0;
    wrapped = 1'b0;
    brightness = 4'd8;
    for (int unsigned k = 1; k < PER; k++) exp_q.push_back(C_OFF);

    // Basic color: red at cnt=3, duty 8
    wait_to(3);
    chk_ready("basic_ready_before", 1'b1);
    drive_req(C_RED);
    tick();
    req_valid = 1'b0;
    chk_ready("basic_ready_drop", 1'b0);
    wait_to(15);
    chk_ready("basic_pend", 1'b0);
    hold_check(C_RED, 8);

    // Request in the wrap cycle: skips one period
    wait_to(15);
    chk_ready("wrapreq_ready", 1'b1);
    drive_req(3'b011);
    push_period(C_RED, 8);
    tick();
    req_valid = 1'b0;
    chk_ready("wrapreq_busy", 1'b0);
    wait_to(15);
    hold_check(3'b011, 8);

    // Brightness 0 with white
    brightness = 4'd0;
    wait_to(3);
    drive_req(C_WHITE);
    tick();
    req_valid = 1'b0;
    wait_to(15);
    hold_check(C_WHITE, 0);

    // Brightness max, same color re-requested
    brightness = 4'd15;
    wait_to(3);
    chk_ready("same_color_ready", 1'b1);
    drive_req(C_WHITE);
    tick();
    req_valid = 1'b0;
    chk_ready("same_color_busy", 1'b0);
    wait_to(15);
    hold_check(C_WHITE, 15);

    // Mid-period brightness change
    brightness = 4'd4;
    wait_to(15);
    push_period(C_WHITE, 4);
    wait_to(2);
    brightness = 4'd12;
    wait_to(15);
    push_period(C_WHITE, 12);
    wait_to(15);

    // Color 000
    wait_to(3);
    drive_req(C_OFF);
    tick();
    req_valid = 1'b0;
    wait_to(15);
    hold_check(C_OFF, 12);

    // Back-to-back requests with req_valid held high
    drive_req(seq[0]);
    chk_ready("b2b_ready_first", 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_ready("b2b_busy", 1'b0);
      if (i < 2) drive_req(seq[i+1]);
      else req_valid = 1'b0;
      wait_to(15);
      chk_ready("b2b_pend", 1'b0);
      for (int p = 0; p < 3; p++) push_period(seq[i], 12);
      repeat (PER) tick();
      chk_ready("b2b_hold1", 1'b0);
      repeat (PER) tick();
      chk_ready("b2b_hold2", 1'b0);
      tick();
      chk_ready("b2b_idle", 1'b1);
    end

    // Asynchronous reset mid-period with led_r high
    wait_to(3);
    chk("pre_reset_led_r", {7'b0, led_r}, 8'h01);
    exp_q.delete();
    rst = 1'b1;
    #1;
    chk_all_off("async_reset_outputs");
    chk_ready("async_reset_ready", 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_off("held_reset_outputs");
    rst = 1'b0;
    tb_cnt = 0;
    wrapped = 1'b0;
    for (int unsigned k = 1; k < 2 * PER; k++) exp_q.push_back(C_OFF);
    wait_to(15);
    chk_ready("post_reset_ready", 1'b1);
    wait_to(15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
